// File: rtl/smp_iter_ctrl_pkg.sv
// Shared types and helpers for the sample-iteration controller (R13 -> R14).
// Default widths match the rasterizer fixed-point format.
package smp_iter_ctrl_pkg;

    localparam int SIGFIG_DEF = 24;
    localparam int RADIX_DEF  = 10;
    localparam int VERTS_DEF  = 3;
    localparam int AXIS_DEF   = 3;

    typedef enum logic {
        WAIT_S = 1'b0,
        TEST_S = 1'b1
    } state_t;

    // Log2 of the subsample grid width; a lower one-hot bit means a finer grid.
    function automatic logic [1:0] ss_w_lg2(input logic [3:0] sub_sample);
        logic [1:0] lg2;
        if (sub_sample[0])      lg2 = 2'd3;
        else if (sub_sample[1]) lg2 = 2'd2;
        else if (sub_sample[2]) lg2 = 2'd1;
        else                    lg2 = 2'd0;
        return lg2;
    endfunction

endpackage

// File: rtl/smp_iter_ctrl_step.sv
// smp_step: raster-order next sample position and last-sample flag for one box.
// All compares use one guard bit so coordinates near the screen edge never wrap.
module smp_step
    import smp_iter_ctrl_pkg::*;
#(
    parameter int SIGFIG = SIGFIG_DEF
) (
    input  logic signed [SIGFIG-1:0] x,
    input  logic signed [SIGFIG-1:0] y,
    input  logic signed [SIGFIG-1:0] ll_x,
    input  logic signed [SIGFIG-1:0] ur_x,
    input  logic signed [SIGFIG-1:0] ur_y,
    input  logic signed [SIGFIG-1:0] stride,
    output logic signed [SIGFIG-1:0] nxt_x,
    output logic signed [SIGFIG-1:0] nxt_y,
    output logic                     nxt_last
);

    function automatic logic signed [SIGFIG:0] ext(input logic signed [SIGFIG-1:0] v);
        return {v[SIGFIG-1], v};
    endfunction

    logic signed [SIGFIG:0] x_sum;
    logic signed [SIGFIG:0] y_sum;
    logic signed [SIGFIG:0] nx_e;
    logic signed [SIGFIG:0] ny_e;
    logic signed [SIGFIG:0] nx_sum;
    logic signed [SIGFIG:0] ny_sum;

    always_comb begin
        x_sum = ext(x) + ext(stride);
        y_sum = ext(y) + ext(stride);
        nx_e  = ext(ll_x);
        ny_e  = y_sum;
        if (x_sum <= ext(ur_x)) begin
            nx_e = x_sum;
            ny_e = ext(y);
        end
        nxt_x    = nx_e[SIGFIG-1:0];
        nxt_y    = ny_e[SIGFIG-1:0];
        // Last once neither axis can take another stride inside the box.
        nx_sum   = nx_e + ext(stride);
        ny_sum   = ny_e + ext(stride);
        nxt_last = (nx_sum > ext(ur_x)) && (ny_sum > ext(ur_y));
    end

endmodule

// File: rtl/smp_iter_ctrl.sv
// Sample-iteration controller: accepts a triangle+box at R13 and walks its samples at R14.
// Optional macro SMP_ITER_PERF_EN adds saturating triangle/sample counters.
module smp_iter_ctrl
    import smp_iter_ctrl_pkg::*;
#(
    parameter int SIGFIG = SIGFIG_DEF,
    parameter int RADIX  = RADIX_DEF,
    parameter int VERTS  = VERTS_DEF,
    parameter int AXIS   = AXIS_DEF
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic signed [1:0][1:0][SIGFIG-1:0]           box_R13S,
    input  logic                                         validTri_R13H,
    input  logic [3:0]                                   subSample_RnnnnU,
    input  logic                                         halt_RnnnnL,
    output logic                                         halt_R13L,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic signed [1:0][SIGFIG-1:0]                sample_R14S,
    output logic                                         validSamp_R14H,
    output logic                                         lastSamp_R14H
`ifdef SMP_ITER_PERF_EN
    ,
    output logic [31:0]                                  triCount_U,
    output logic [31:0]                                  sampCount_U
`endif
);

    localparam logic [SIGFIG-1:0] STRIDE_ONE = {{(SIGFIG-1){1'b0}}, 1'b1};

    state_t state, state_nxt;

    logic                     accept;
    logic signed [SIGFIG-1:0] stride_new;
    logic signed [SIGFIG-1:0] ll_x_p0, ur_x_p0, ur_y_p0, stride_p0;
    logic signed [SIGFIG-1:0] cur_x, cur_y, nxt_x, nxt_y;
    logic                     nxt_last;

    assign accept     = (state == WAIT_S) && validTri_R13H && halt_RnnnnL;
    assign stride_new = STRIDE_ONE << (RADIX - int'(ss_w_lg2(subSample_RnnnnU)));
    assign cur_x      = sample_R14S[0];
    assign cur_y      = sample_R14S[1];

    always @(posedge clk) begin
        if (rst && accept) begin
            assert ($onehot(subSample_RnnnnU));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT_S;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (halt_RnnnnL) begin
            case (state)
                WAIT_S:  if (validTri_R13H) state_nxt = TEST_S;
                TEST_S:  if (lastSamp_R14H) state_nxt = WAIT_S;
                default: state_nxt = WAIT_S;
            endcase
        end
    end

    always_comb begin
        halt_R13L = halt_RnnnnL & (state == WAIT_S);
    end

    smp_step #(.SIGFIG(SIGFIG)) u_step (
        .x        (cur_x),
        .y        (cur_y),
        .ll_x     (ll_x_p0),
        .ur_x     (ur_x_p0),
        .ur_y     (ur_y_p0),
        .stride   (stride_p0),
        .nxt_x    (nxt_x),
        .nxt_y    (nxt_y),
        .nxt_last (nxt_last)
    );

    // R13 -> box/stride capture; only consulted while iterating, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            ll_x_p0   <= box_R13S[0][0];
            ur_x_p0   <= box_R13S[1][0];
            ur_y_p0   <= box_R13S[1][1];
            stride_p0 <= stride_new;
        end
    end

    // R14 sample outputs; all hold while downstream halts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tri_R14S       <= '0;
            sample_R14S    <= '0;
            validSamp_R14H <= 1'b0;
            lastSamp_R14H  <= 1'b0;
        end else if (halt_RnnnnL) begin
            if (state == WAIT_S) begin
                validSamp_R14H <= 1'b0;
                lastSamp_R14H  <= 1'b0;
                if (validTri_R13H) begin
                    tri_R14S       <= tri_R13S;
                    sample_R14S    <= box_R13S[0];
                    validSamp_R14H <= 1'b1;
                    lastSamp_R14H  <= (box_R13S[0] == box_R13S[1]);
                end
            end else if (lastSamp_R14H) begin
                validSamp_R14H <= 1'b0;
                lastSamp_R14H  <= 1'b0;
            end else begin
                sample_R14S    <= {nxt_y, nxt_x};
                lastSamp_R14H  <= nxt_last;
            end
        end
    end

`ifdef SMP_ITER_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            triCount_U  <= '0;
            sampCount_U <= '0;
        end else begin
            if (accept && (triCount_U != '1))
                triCount_U <= triCount_U + 32'd1;
            if (validSamp_R14H && halt_RnnnnL && (sampCount_U != '1))
                sampCount_U <= sampCount_U + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_smp_iter_ctrl.sv
// Directed bench for smp_iter_ctrl: raster walk, single-sample box, stall, back-to-back, async reset.
module tb_smp_iter_ctrl;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;

    logic clk = 1'b0;
    logic rst;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic signed [1:0][1:0][SIGFIG-1:0]           box_R13S;
    logic                                         validTri_R13H;
    logic [3:0]                                   subSample_RnnnnU;
    logic                                         halt_RnnnnL;
    logic                                         halt_R13L;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic signed [1:0][SIGFIG-1:0]                sample_R14S;
    logic                                         validSamp_R14H;
    logic                                         lastSamp_R14H;
`ifdef SMP_ITER_PERF_EN
    logic [31:0] triCount_U, sampCount_U;
`endif

    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_a, tri_b, tri_zero;

    int n_cmp = 0;
    int n_err = 0;

    int t1x[6] = '{0, 1024, 2048, 0, 1024, 2048};
    int t1y[6] = '{0, 0, 0, 1024, 1024, 1024};

    smp_iter_ctrl #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS)) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .halt_R13L        (halt_R13L),
        .tri_R14S         (tri_R14S),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H),
        .lastSamp_R14H    (lastSamp_R14H)
`ifdef SMP_ITER_PERF_EN
        ,
        .triCount_U       (triCount_U),
        .sampCount_U      (sampCount_U)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int ex, input int ey,
                           input logic ev, input logic el, input logic eh);
        logic [SIGFIG-1:0] sx, sy;
        sx = ex[SIGFIG-1:0];
        sy = ey[SIGFIG-1:0];
        chk({tag, ".valid"}, validSamp_R14H, ev);
        chk({tag, ".last"}, lastSamp_R14H, el);
        chk({tag, ".halt13"}, halt_R13L, eh);
        if (ev) begin
            chk({tag, ".x"}, sample_R14S[0], sx);
            chk({tag, ".y"}, sample_R14S[1], sy);
        end
    endtask

    task automatic set_box(input int llx, input int lly, input int urx, input int ury);
        box_R13S[0][0] = llx[SIGFIG-1:0];
        box_R13S[0][1] = lly[SIGFIG-1:0];
        box_R13S[1][0] = urx[SIGFIG-1:0];
        box_R13S[1][1] = ury[SIGFIG-1:0];
    endtask

    initial begin
        for (int v = 0; v < VERTS; v++) begin
            for (int a = 0; a < AXIS; a++) begin
                tri_a[v][a] = SIGFIG'(v * AXIS + a + 1);
                tri_b[v][a] = SIGFIG'(24'h100 * (v + 1) + a);
            end
        end
        tri_zero = '0;

        rst              = 1'b0;
        validTri_R13H    = 1'b0;
        halt_RnnnnL      = 1'b1;
        subSample_RnnnnU = 4'b1000;
        tri_R13S         = '0;
        box_R13S         = '0;

        // Reset state
        tick();
        tick();
        chk_out("rst", 0, 0, 1'b0, 1'b0, 1'b1);
        chk("rst.samp", sample_R14S, 48'h0);
        chk("rst.tri", tri_R14S, tri_zero);
`ifdef SMP_ITER_PERF_EN
        chk("rst.tricnt", triCount_U, 32'd0);
        chk("rst.sampcnt", sampCount_U, 32'd0);
`endif
        rst = 1'b1;
        tick();

        // Idle without a valid triangle, then stall blocks acceptance
        chk_out("idle", 0, 0, 1'b0, 1'b0, 1'b1);
        tri_R13S = tri_a;
        set_box(0, 0, 2048, 1024);
        validTri_R13H = 1'b1;
        halt_RnnnnL   = 1'b0;
        #1;
        chk("stallwait.halt13", halt_R13L, 1'b0);
        tick();
        chk_out("stallwait", 0, 0, 1'b0, 1'b0, 1'b0);
        halt_RnnnnL = 1'b1;
        #1;
        chk("unstall.halt13", halt_R13L, 1'b1);

        // Test 1: 3x2 box, stride 1024
        tick();
        chk_out("t1.s0", 0, 0, 1'b1, 1'b0, 1'b0);
        chk("t1.tri", tri_R14S, tri_a);
        validTri_R13H = 1'b0;
        for (int i = 1; i < 6; i++) begin
            tick();
            chk_out($sformatf("t1.s%0d", i), t1x[i], t1y[i], 1'b1, (i == 5), 1'b0);
        end
        tick();
        chk_out("t1.done", 0, 0, 1'b0, 1'b0, 1'b1);

        // Test 2: single-sample box, stride 512
        subSample_RnnnnU = 4'b0100;
        set_box(512, 512, 512, 512);
        tri_R13S      = tri_b;
        validTri_R13H = 1'b1;
        tick();
        chk_out("t2.s0", 512, 512, 1'b1, 1'b1, 1'b0);
        chk("t2.tri", tri_R14S, tri_b);
        validTri_R13H = 1'b0;
        tick();
        chk_out("t2.done", 0, 0, 1'b0, 1'b0, 1'b1);
`ifdef SMP_ITER_PERF_EN
        chk("t2.tricnt", triCount_U, 32'd2);
        chk("t2.sampcnt", sampCount_U, 32'd7);
`endif

        // Test 3: downstream stall for 3 cycles after the 2nd sample
        subSample_RnnnnU = 4'b1000;
        set_box(0, 0, 2048, 1024);
        tri_R13S      = tri_a;
        validTri_R13H = 1'b1;
        tick();
        chk_out("t3.s0", 0, 0, 1'b1, 1'b0, 1'b0);
        validTri_R13H = 1'b0;
        tick();
        chk_out("t3.s1", 1024, 0, 1'b1, 1'b0, 1'b0);
        halt_RnnnnL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("t3.hold%0d", i), 1024, 0, 1'b1, 1'b0, 1'b0);
        end
        halt_RnnnnL = 1'b1;
        for (int i = 2; i < 6; i++) begin
            tick();
            chk_out($sformatf("t3.s%0d", i), t1x[i], t1y[i], 1'b1, (i == 5), 1'b0);
        end
        tick();
        chk_out("t3.done", 0, 0, 1'b0, 1'b0, 1'b1);

        // Test 4: back-to-back; first box sits at the positive screen edge
        set_box(8386560, 0, 8387584, 0);
        tri_R13S      = tri_a;
        validTri_R13H = 1'b1;
        tick();
        chk_out("t4.a0", 8386560, 0, 1'b1, 1'b0, 1'b0);
        tri_R13S = tri_b;
        set_box(-2048, -1024, -2048, -1024);
        tick();
        chk_out("t4.a1", 8387584, 0, 1'b1, 1'b1, 1'b0);
        chk("t4.triA", tri_R14S, tri_a);
        tick();
        chk_out("t4.gap", 0, 0, 1'b0, 1'b0, 1'b1);
        chk("t4.triHold", tri_R14S, tri_a);
        tick();
        chk_out("t4.b0", -2048, -1024, 1'b1, 1'b1, 1'b0);
        chk("t4.triB", tri_R14S, tri_b);
        validTri_R13H = 1'b0;
        tick();
        chk_out("t4.done", 0, 0, 1'b0, 1'b0, 1'b1);

        // Test 5: asynchronous reset at the 3rd sample
        set_box(0, 0, 2048, 1024);
        tri_R13S      = tri_a;
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        tick();
        tick();
        chk_out("t5.s2", 2048, 0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk_out("t5.rst", 0, 0, 1'b0, 1'b0, 1'b1);
        chk("t5.rst.samp", sample_R14S, 48'h0);
        chk("t5.rst.tri", tri_R14S, tri_zero);
        rst = 1'b1;
        tick();
        chk_out("t5.idle", 0, 0, 1'b0, 1'b0, 1'b1);
        subSample_RnnnnU = 4'b0001;
        set_box(256, 128, 384, 128);
        tri_R13S      = tri_b;
        validTri_R13H = 1'b1;
        tick();
        chk_out("t5.n0", 256, 128, 1'b1, 1'b0, 1'b0);
        chk("t5.tri", tri_R14S, tri_b);
        validTri_R13H = 1'b0;
        tick();
        chk_out("t5.n1", 384, 128, 1'b1, 1'b1, 1'b0);
        tick();
        chk_out("t5.done", 0, 0, 1'b0, 1'b0, 1'b1);
`ifdef SMP_ITER_PERF_EN
        chk("t5.tricnt", triCount_U, 32'd1);
        chk("t5.sampcnt", sampCount_U, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
